xy2_100_rx: RTL and testbench
=============================

XY2_100_RX -- requirements
Module: xy2_100_rx

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 400, clk_ref cycles without an xy_clk falling edge before the link is declared lost (20 us at 20 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth.
REQ-003 clk_ref  input  1  single clock for all logic, 20 MHz.
REQ-004 sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 xy_clk  input  1  XY2-100 bit clock, 2 MHz, asynchronous to clk_ref.
REQ-006 xy_sync  input  1  frame sync: high for bits 0-18, low for bit 19 (parity).
REQ-007 xy_x / xy_y  input  1 each  X and Y serial channels, MSB first.
REQ-008 xy_status  output  1  serial status channel back to the controller.
REQ-009 status_word  input  16  status value to transmit, latched at frame end.
REQ-010 pos_x / pos_y  output  16 each  last good position words (feed pos_pid pos_pre).
REQ-011 dvalid  output  1  one-cycle pulse when pos_x/pos_y update.
REQ-012 link_ok  output  1  high while frames arrive within TIMEOUT_CYCLES.
REQ-013 err_parity / err_frame  output  8 each  saturating error counters.

Function
REQ-014 All xy_* inputs SHALL pass through SYNC_STAGES flops; xy_clk edges SHALL be detected from the last synchronized stage against one further delayed copy.
REQ-015 On each detected xy_clk falling edge, the block SHALL shift xy_x, xy_y and xy_sync into 20-bit shift registers and increment a 5-bit bit counter.
REQ-016 A sampled xy_sync=1 while the bit counter is already 19 SHALL increment err_frame and restart the count at 1 (the current bit counts as bit 0).
REQ-017 A sampled xy_sync=0 SHALL end the frame: if the bit counter was exactly 19, the frame SHALL be checked; otherwise err_frame SHALL increment and nothing is output; the counter SHALL return to 0 in both cases.
REQ-018 Frame check: bits 19..17 of each channel SHALL equal 3'b001, and the XOR of all 20 bits of each channel SHALL be 0 (even parity).
REQ-019 Control mismatch on either channel SHALL increment err_frame; a parity failure on either channel SHALL increment err_parity once per frame. Control mismatch takes precedence.
REQ-020 On a good frame, pos_x/pos_y SHALL load bits 16..1 and dvalid SHALL pulse in the clk_ref cycle after the edge-detect cycle; pin-to-dvalid latency SHALL be at most SYNC_STAGES+2 cycles.
REQ-021 On a bad frame, pos_x/pos_y SHALL hold their values and dvalid SHALL stay low.
REQ-022 A timeout counter SHALL clear on every falling edge; at TIMEOUT_CYCLES, link_ok SHALL drop and the bit counter SHALL clear. link_ok SHALL rise after the next good frame.
REQ-023 Error counters SHALL saturate at 8'hFF and SHALL never wrap.
REQ-024 At every frame end (good or bad), the transmitter SHALL latch {3'b001, status_word, p}, with p set so that the 20-bit frame has even parity.
REQ-025 On each detected xy_clk rising edge after the latch, xy_status SHALL present the next bit, MSB first; after 20 bits, it SHALL hold 0 until the next latch.
REQ-026 If a new frame ends while the transmitter is still sending, the transmitter SHALL reload and restart from bit 19.

Reset
REQ-027 While sys_rst is high, pos_x, pos_y, dvalid, link_ok, err_parity, err_frame and xy_status SHALL all be 0.
REQ-028 While sys_rst is high, all counters, shift registers and synchronizers SHALL be 0.
REQ-029 A reset mid-frame SHALL discard the partial frame; the first complete frame after release SHALL be accepted only if it starts after release.

Structure
REQ-030 Package xy2_pkg SHALL hold FRAME_BITS=20, CTRL_BITS=3'b001 and the error-counter width.
REQ-031 One sub-module, xy2_sync_edge, SHALL implement the synchronizer plus rise/fall pulse generation, instantiated per input.

Verification
REQ-032 X=16'h8000, Y=16'h1234, both parity 0, good frame -> dvalid pulses once; pos_x=8000, pos_y=1234; link_ok=1.
REQ-033 Same frame with the Y parity bit flipped -> err_parity=1; pos values unchanged; no dvalid.
REQ-034 xy_sync low after 15 bits -> err_frame=1; next good frame with X=16'h0001 is accepted.
REQ-035 status_word=16'hA5A5 -> xy_status sequence is 001, A5A5 MSB first, parity 1.
REQ-036 xy_clk stopped for 400 cycles -> link_ok=0; a good frame afterwards -> link_ok=1.
REQ-037 sys_rst asserted at bit 10 -> all outputs 0; the next whole frame decodes correctly; 300 bad frames -> err_parity holds at FF.

Source files
------------

// File: rtl/xy2_pkg.sv
// Shared constants and helpers for the XY2-100 receiver: frame geometry,
// control-bit pattern, error-counter width and the frame-decode result type.
package xy2_pkg;

    localparam int FRAME_BITS = 20;
    localparam logic [2:0] CTRL_BITS = 3'b001;
    localparam int ERR_W = 8;

    typedef enum logic [2:0] {
        FR_NONE    = 3'd0,
        FR_GOOD    = 3'd1,
        FR_PARITY  = 3'd2,
        FR_CTRL    = 3'd3,
        FR_LENGTH  = 3'd4,
        FR_OVERRUN = 3'd5
    } frame_res_e;

    // Error counters stick at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

    function automatic logic even_parity_ok(input logic [FRAME_BITS-1:0] w);
        return ~(^w);
    endfunction

endpackage

// File: rtl/xy2_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses taken from the last stage against one further delayed copy.
module xy2_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              dly_r;

    // Synchronizer chain plus the delayed copy used for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
            dly_r  <= 1'b0;
        end else begin
            sync_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            dly_r <= sync_r[STAGES-1];
        end
    end

    assign q    = sync_r[STAGES-1];
    assign rise = q & ~dly_r;
    assign fall = ~q & dly_r;

endmodule

// File: rtl/xy2_100_rx.sv
// XY2-100 galvo-link receiver: decodes X/Y position frames, tracks link health
// and error counts, and serialises a status word back on xy_status.
module xy2_100_rx
    import xy2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 400,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk_ref,
    input  logic             sys_rst,
    input  logic             xy_clk,
    input  logic             xy_sync,
    input  logic             xy_x,
    input  logic             xy_y,
    input  logic [15:0]      status_word,
    output logic             xy_status,
    output logic [15:0]      pos_x,
    output logic [15:0]      pos_y,
    output logic             dvalid,
    output logic             link_ok,
    output logic [ERR_W-1:0] err_parity,
    output logic [ERR_W-1:0] err_frame
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic clk_rise_s, clk_fall_s, unused_clk_q;
    logic sync_s, x_s, y_s;
    logic [2:0] unused_rise, unused_fall;

    xy2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk  (.clk(clk_ref), .rst(sys_rst), .d(xy_clk),  .q(unused_clk_q), .rise(clk_rise_s),     .fall(clk_fall_s));
    xy2_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk_ref), .rst(sys_rst), .d(xy_sync), .q(sync_s),       .rise(unused_rise[0]), .fall(unused_fall[0]));
    xy2_sync_edge #(.STAGES(SYNC_STAGES)) u_x    (.clk(clk_ref), .rst(sys_rst), .d(xy_x),    .q(x_s),          .rise(unused_rise[1]), .fall(unused_fall[1]));
    xy2_sync_edge #(.STAGES(SYNC_STAGES)) u_y    (.clk(clk_ref), .rst(sys_rst), .d(xy_y),    .q(y_s),          .rise(unused_rise[2]), .fall(unused_fall[2]));

    logic [FRAME_BITS-1:0] sr_x_r, sr_y_r, sr_sync_r;
    logic [FRAME_BITS-1:0] sx_next_s, sy_next_s, ss_next_s, tx_load_s;
    logic [FRAME_BITS-1:0] tx_sr_r;
    logic [4:0]            bit_cnt_r, tx_cnt_r;
    logic [TO_W-1:0]       to_cnt_r;
    logic                  lost_s, frame_end_s;
    frame_res_e            res_s;

    // Frame decode: the check uses the shift registers including the bit sampled now
    always_comb begin
        sx_next_s   = {sr_x_r[FRAME_BITS-2:0], x_s};
        sy_next_s   = {sr_y_r[FRAME_BITS-2:0], y_s};
        ss_next_s   = {sr_sync_r[FRAME_BITS-2:0], sync_s};
        frame_end_s = clk_fall_s & ~sync_s;
        lost_s      = (to_cnt_r == TO_MAX) & ~clk_fall_s;
        tx_load_s   = {CTRL_BITS, status_word, ^{CTRL_BITS, status_word}};
        res_s       = FR_NONE;
        if (clk_fall_s) begin
            if (!sync_s) begin
                if (bit_cnt_r != 5'd19 || ss_next_s != 20'hFFFFE) begin
                    res_s = FR_LENGTH;
                end else if (sx_next_s[19:17] != CTRL_BITS || sy_next_s[19:17] != CTRL_BITS) begin
                    res_s = FR_CTRL;
                end else if (!even_parity_ok(sx_next_s) || !even_parity_ok(sy_next_s)) begin
                    res_s = FR_PARITY;
                end else begin
                    res_s = FR_GOOD;
                end
            end else if (bit_cnt_r == 5'd19) begin
                res_s = FR_OVERRUN;
            end else begin
                res_s = FR_NONE;
            end
        end else begin
            res_s = FR_NONE;
        end
    end

    // Receive shifting, bit counting, timeout, position and error registers
    always_ff @(posedge clk_ref or posedge sys_rst) begin
        if (sys_rst) begin
            sr_x_r     <= {FRAME_BITS{1'b0}};
            sr_y_r     <= {FRAME_BITS{1'b0}};
            sr_sync_r  <= {FRAME_BITS{1'b0}};
            bit_cnt_r  <= 5'd0;
            to_cnt_r   <= {TO_W{1'b0}};
            pos_x      <= 16'h0000;
            pos_y      <= 16'h0000;
            dvalid     <= 1'b0;
            link_ok    <= 1'b0;
            err_parity <= {ERR_W{1'b0}};
            err_frame  <= {ERR_W{1'b0}};
        end else begin
            dvalid <= 1'b0;
            if (clk_fall_s) begin
                sr_x_r    <= sx_next_s;
                sr_y_r    <= sy_next_s;
                sr_sync_r <= ss_next_s;
                to_cnt_r  <= {TO_W{1'b0}};
            end else if (to_cnt_r != TO_MAX) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
            case (res_s)
                FR_NONE: begin
                    if (clk_fall_s) begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                    end else if (lost_s) begin
                        bit_cnt_r <= 5'd0;
                        link_ok   <= 1'b0;
                    end
                end
                // Sync never dropped: the current bit becomes bit 0 of a new frame
                FR_OVERRUN: begin
                    bit_cnt_r <= 5'd1;
                    err_frame <= sat_inc(err_frame);
                end
                FR_LENGTH, FR_CTRL: begin
                    bit_cnt_r <= 5'd0;
                    err_frame <= sat_inc(err_frame);
                end
                FR_PARITY: begin
                    bit_cnt_r  <= 5'd0;
                    err_parity <= sat_inc(err_parity);
                end
                FR_GOOD: begin
                    bit_cnt_r <= 5'd0;
                    pos_x     <= sx_next_s[16:1];
                    pos_y     <= sy_next_s[16:1];
                    dvalid    <= 1'b1;
                    link_ok   <= 1'b1;
                end
                default: begin
                    bit_cnt_r <= 5'd0;
                end
            endcase
        end
    end

    // Status transmitter: reloads at every frame end, shifts MSB first on xy_clk rises
    always_ff @(posedge clk_ref or posedge sys_rst) begin
        if (sys_rst) begin
            tx_sr_r   <= {FRAME_BITS{1'b0}};
            tx_cnt_r  <= 5'd0;
            xy_status <= 1'b0;
        end else if (frame_end_s) begin
            tx_sr_r  <= tx_load_s;
            tx_cnt_r <= 5'd20;
        end else if (clk_rise_s) begin
            if (tx_cnt_r != 5'd0) begin
                xy_status <= tx_sr_r[FRAME_BITS-1];
                tx_sr_r   <= {tx_sr_r[FRAME_BITS-2:0], 1'b0};
                tx_cnt_r  <= tx_cnt_r - 5'd1;
            end else begin
                xy_status <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xy2_100_rx.sv
// Directed self-checking bench for xy2_100_rx: frames are bit-banged at
// 2 MHz against a 20 MHz clk_ref and every outcome is checked against hand values.
module tb_xy2_100_rx;

    logic        clk_ref = 1'b0;
    logic        sys_rst = 1'b1;
    logic        xy_clk = 1'b0, xy_sync = 1'b0, xy_x = 1'b0, xy_y = 1'b0;
    logic [15:0] status_word = 16'h0000;
    logic        xy_status, dvalid, link_ok;
    logic [15:0] pos_x, pos_y;
    logic [7:0]  err_parity, err_frame;

    int checks = 0;
    int passed = 0;

    logic [19:0] st_cap;
    int          dv_cnt;
    int          last_lat;

    always #25 clk_ref = ~clk_ref;

    xy2_100_rx #(.TIMEOUT_CYCLES(400), .SYNC_STAGES(2)) dut (
        .clk_ref(clk_ref), .sys_rst(sys_rst), .xy_clk(xy_clk), .xy_sync(xy_sync),
        .xy_x(xy_x), .xy_y(xy_y), .status_word(status_word), .xy_status(xy_status),
        .pos_x(pos_x), .pos_y(pos_y), .dvalid(dvalid), .link_ok(link_ok),
        .err_parity(err_parity), .err_frame(err_frame)
    );

    function automatic logic [19:0] make_frame(input logic [15:0] d);
        logic [18:0] b;
        b = {3'b001, d};
        return {b, ^b};
    endfunction

    // Sends bits n-1..0; data changes on the xy_clk rise, DUT samples on the fall.
    task automatic send_word(input logic [19:0] fx, input logic [19:0] fy, input logic [19:0] fs, input int n);
        st_cap = 20'h00000;
        dv_cnt = 0;
        last_lat = 0;
        for (int i = n - 1; i >= 0; i--) begin
            xy_clk = 1'b1; xy_x = fx[i]; xy_y = fy[i]; xy_sync = fs[i];
            repeat (5) begin
                @(negedge clk_ref);
                if (dvalid) dv_cnt++;
            end
            st_cap = {st_cap[18:0], xy_status};
            xy_clk = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk_ref);
                if (dvalid) begin
                    dv_cnt++;
                    if (i == 0 && last_lat == 0) last_lat = k;
                end
            end
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge clk_ref);
        checks++; if (pos_x !== 16'h0000) $display("FAIL reset_pos_x got=%h exp=0000", pos_x); else passed++;
        checks++; if (pos_y !== 16'h0000) $display("FAIL reset_pos_y got=%h exp=0000", pos_y); else passed++;
        checks++; if ({dvalid, link_ok, xy_status} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {dvalid, link_ok, xy_status}); else passed++;
        checks++; if ({err_parity, err_frame} !== 16'h0000) $display("FAIL reset_errs got=%h exp=0000", {err_parity, err_frame}); else passed++;
        sys_rst = 1'b0;
        repeat (3) @(negedge clk_ref);
    endtask

    task automatic test_good_frame();
        status_word = 16'hA5A5;
        send_word(make_frame(16'h8000), make_frame(16'h1234), 20'hFFFFE, 20);
        checks++; if (dv_cnt != 1) $display("FAIL good_dvalid_count got=%0d exp=1", dv_cnt); else passed++;
        checks++; if (last_lat < 1 || last_lat > 4) $display("FAIL good_latency got=%0d exp=1..4", last_lat); else passed++;
        checks++; if (pos_x !== 16'h8000) $display("FAIL good_pos_x got=%h exp=8000", pos_x); else passed++;
        checks++; if (pos_y !== 16'h1234) $display("FAIL good_pos_y got=%h exp=1234", pos_y); else passed++;
        checks++; if (link_ok !== 1'b1) $display("FAIL good_link_ok got=%b exp=1", link_ok); else passed++;
        checks++; if ({err_parity, err_frame} !== 16'h0000) $display("FAIL good_errs got=%h exp=0000", {err_parity, err_frame}); else passed++;
        checks++; if (st_cap !== 20'h00000) $display("FAIL status_idle got=%h exp=00000", st_cap); else passed++;
    endtask

    task automatic test_parity_and_status();
        status_word = 16'h0000;
        send_word(make_frame(16'h8000), make_frame(16'h1234) ^ 20'h00001, 20'hFFFFE, 20);
        checks++; if (err_parity !== 8'd1) $display("FAIL par_err_parity got=%0d exp=1", err_parity); else passed++;
        checks++; if (err_frame !== 8'd0) $display("FAIL par_err_frame got=%0d exp=0", err_frame); else passed++;
        checks++; if (dv_cnt != 0) $display("FAIL par_dvalid got=%0d exp=0", dv_cnt); else passed++;
        checks++; if ({pos_x, pos_y} !== 32'h8000_1234) $display("FAIL par_pos_hold got=%h exp=80001234", {pos_x, pos_y}); else passed++;
        checks++; if (st_cap !== 20'h34B4B) $display("FAIL status_a5a5 got=%h exp=34b4b", st_cap); else passed++;
    endtask

    task automatic test_short_frame();
        send_word(20'h00000, 20'h00000, 20'h0FFFE, 16);
        checks++; if (err_frame !== 8'd1) $display("FAIL short_err_frame got=%0d exp=1", err_frame); else passed++;
        checks++; if (dv_cnt != 0) $display("FAIL short_dvalid got=%0d exp=0", dv_cnt); else passed++;
        send_word(make_frame(16'h0001), make_frame(16'h0002), 20'hFFFFE, 20);
        checks++; if ({pos_x, pos_y} !== 32'h0001_0002) $display("FAIL short_next_pos got=%h exp=00010002", {pos_x, pos_y}); else passed++;
        checks++; if (dv_cnt != 1) $display("FAIL short_next_dvalid got=%0d exp=1", dv_cnt); else passed++;
        checks++; if (st_cap !== 20'h20001) $display("FAIL status_zero got=%h exp=20001", st_cap); else passed++;
    endtask

    task automatic test_ctrl_mismatch();
        // Control bits become 011 and parity is also broken: the frame error wins
        send_word(make_frame(16'h5555) ^ 20'h40000, make_frame(16'h5555), 20'hFFFFE, 20);
        checks++; if (err_frame !== 8'd2) $display("FAIL ctrl_err_frame got=%0d exp=2", err_frame); else passed++;
        checks++; if (err_parity !== 8'd1) $display("FAIL ctrl_err_parity got=%0d exp=1", err_parity); else passed++;
        checks++; if (dv_cnt != 0 || {pos_x, pos_y} !== 32'h0001_0002) $display("FAIL ctrl_hold got=%0d/%h exp=0/00010002", dv_cnt, {pos_x, pos_y}); else passed++;
    endtask

    task automatic test_overrun_resync();
        send_word(20'h00000, 20'h00000, 20'hFFFFF, 19);
        send_word(make_frame(16'h00FF), make_frame(16'hFF00), 20'hFFFFE, 20);
        checks++; if (err_frame !== 8'd3) $display("FAIL ovr_err_frame got=%0d exp=3", err_frame); else passed++;
        checks++; if ({pos_x, pos_y} !== 32'h00FF_FF00) $display("FAIL ovr_pos got=%h exp=00ffff00", {pos_x, pos_y}); else passed++;
        checks++; if (dv_cnt != 1) $display("FAIL ovr_dvalid got=%0d exp=1", dv_cnt); else passed++;
    endtask

    task automatic test_timeout();
        logic [19:0] fx, fy;
        fx = make_frame(16'h0ABC);
        fy = make_frame(16'h0DEF);
        send_word(20'h00000, 20'h00000, 20'hFFFFF, 10);
        repeat (300) @(negedge clk_ref);
        checks++; if (link_ok !== 1'b1) $display("FAIL to_link_before got=%b exp=1", link_ok); else passed++;
        repeat (120) @(negedge clk_ref);
        checks++; if (link_ok !== 1'b0) $display("FAIL to_link_lost got=%b exp=0", link_ok); else passed++;
        send_word(fx >> 1, fy >> 1, 20'h7FFFF, 19);
        checks++; if (link_ok !== 1'b0) $display("FAIL to_link_partial got=%b exp=0", link_ok); else passed++;
        send_word(fx, fy, 20'hFFFFE, 1);
        checks++; if (link_ok !== 1'b1) $display("FAIL to_link_back got=%b exp=1", link_ok); else passed++;
        checks++; if ({pos_x, pos_y} !== 32'h0ABC_0DEF) $display("FAIL to_pos got=%h exp=0abc0def", {pos_x, pos_y}); else passed++;
        checks++; if (err_frame !== 8'd3) $display("FAIL to_err_frame got=%0d exp=3", err_frame); else passed++;
    endtask

    task automatic test_reset_midframe_and_saturation();
        logic [19:0] fx, fy;
        fx = make_frame(16'h4321);
        fy = make_frame(16'hABCD);
        send_word(fx >> 10, fy >> 10, 20'hFFFFE >> 10, 10);
        sys_rst = 1'b1;
        repeat (3) @(negedge clk_ref);
        checks++; if ({pos_x, pos_y} !== 32'h0) $display("FAIL mid_rst_pos got=%h exp=00000000", {pos_x, pos_y}); else passed++;
        checks++; if ({dvalid, link_ok, xy_status, err_parity, err_frame} !== 19'h0) $display("FAIL mid_rst_other got=%h exp=0", {dvalid, link_ok, xy_status, err_parity, err_frame}); else passed++;
        sys_rst = 1'b0;
        repeat (3) @(negedge clk_ref);
        send_word(fx, fy, 20'hFFFFE, 20);
        checks++; if ({pos_x, pos_y} !== 32'h4321_ABCD) $display("FAIL mid_next_pos got=%h exp=4321abcd", {pos_x, pos_y}); else passed++;
        checks++; if ({err_parity, err_frame} !== 16'h0000 || link_ok !== 1'b1) $display("FAIL mid_next_state got=%h/%b exp=0000/1", {err_parity, err_frame}, link_ok); else passed++;
        for (int f = 0; f < 300; f++) begin
            send_word(fx ^ 20'h00001, fy, 20'hFFFFE, 20);
            if (f == 253) begin
                checks++; if (err_parity !== 8'hFE) $display("FAIL sat_254 got=%h exp=fe", err_parity); else passed++;
            end
            if (f == 254) begin
                checks++; if (err_parity !== 8'hFF) $display("FAIL sat_255 got=%h exp=ff", err_parity); else passed++;
            end
        end
        checks++; if (err_parity !== 8'hFF) $display("FAIL sat_300 got=%h exp=ff", err_parity); else passed++;
        checks++; if (err_frame !== 8'h00 || {pos_x, pos_y} !== 32'h4321_ABCD) $display("FAIL sat_other got=%h/%h exp=00/4321abcd", err_frame, {pos_x, pos_y}); else passed++;
    endtask

    initial begin
        @(negedge clk_ref);
        test_reset();
        test_good_frame();
        test_parity_and_status();
        test_short_frame();
        test_ctrl_mismatch();
        test_overrun_resync();
        test_timeout();
        test_reset_midframe_and_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
